// File: rtl/slow_window_ctrl_pkg.sv
// Shared definitions for the slow-peripheral speed window controller:
// FSM encodings, peripheral class bit positions and prescaler defaults.
package slow_window_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int NUM_CLS  = 6;
    localparam int CLS_IACK = 5;
    localparam int CLS_VIA  = 4;
    localparam int CLS_IWM  = 3;
    localparam int CLS_SCC  = 2;
    localparam int CLS_SCSI = 1;
    localparam int CLS_SND  = 0;

    localparam int DEFAULT_PRESCALE = 1024;
    localparam int DEFAULT_PRE_W    = 10;

    typedef logic [NUM_CLS-1:0] cls_vec_t;

    // True when the selected peripheral class has its slow enable set.
    function automatic logic class_hit(input cls_vec_t sel, input cls_vec_t slow);
        return |(sel & slow);
    endfunction

endpackage

// File: rtl/slow_tick_prescaler.sv
// Divides CLK down to one-cycle timeout ticks, PRESCALE cycles apart.
// Counts only while enabled; clear has priority and restarts the period.
module slow_tick_prescaler
    import slow_window_ctrl_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PRE_W    = DEFAULT_PRE_W
) (
    input  logic CLK,
    input  logic POR,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = en & ~clr & (pre_q == LAST);

    // NOTE: next-state logic assigns its output first so no path can infer a latch.
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (POR) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/slow_window_ctrl.sv
// Opens or re-arms a slow-speed window on bus accesses to slow-enabled
// peripheral classes and holds SlowMode for SlowTimeout prescaled ticks.
module slow_window_ctrl
    import slow_window_ctrl_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PRE_W    = DEFAULT_PRE_W
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       SelIACK,
    input  logic       SelVIA,
    input  logic       SelIWM,
    input  logic       SelSCC,
    input  logic       SelSCSI,
    input  logic       SelSnd,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowMode,
    output logic       ClockGate,
    output logic       WinActive
);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       slow_mode_q, slow_mode_d;
    logic       clock_gate_q, clock_gate_d;
    logic       bact_q;
    logic       hit;
    logic       tick;
    cls_vec_t   sel_vec;
    cls_vec_t   slow_vec;

    assign sel_vec  = {SelIACK, SelVIA, SelIWM, SelSCC, SelSCSI, SelSnd};
    assign slow_vec = {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd};
    assign hit      = BACT & ~bact_q & class_hit(sel_vec, slow_vec);

    // Period restarts whenever the window is (re)entered, so HOLD lasts cnt*PRESCALE cycles.
    slow_tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .CLK  (CLK),
        .POR  (POR),
        .clr  (state_q != ST_HOLD),
        .en   (state_q == ST_HOLD),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = SlowTimeout;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A fresh hit outranks a coincident tick; the count reloads on leaving ACCESS.
                if (hit) begin
                    state_d = ST_ACCESS;
                end else if (tick) begin
                    if (cnt_q == 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        slow_mode_d  = (state_d != ST_IDLE);
        clock_gate_d = slow_mode_d & SlowClockGate;
    end

    always_ff @(posedge CLK) begin
        if (POR) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            slow_mode_q  <= 1'b0;
            clock_gate_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slow_mode_q  <= slow_mode_d;
            clock_gate_q <= clock_gate_d;
        end
    end

    // NOTE: the edge detector is left out of reset so an access held across POR is not seen as new.
    always_ff @(posedge CLK) begin
        bact_q <= BACT;
    end

    assign SlowMode  = slow_mode_q;
    assign ClockGate = clock_gate_q;
    assign WinActive = (state_q != ST_IDLE);

endmodule
